line_serializer: RTL and testbench
==================================

LINE_SERIALIZER -- requirements
Module: line_serializer

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, giving the width of one cache word in bits.
REQ-002 The block SHALL have parameter LINE_WORDS, default 16, giving the number of words per line; only power-of-two values are legal.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 line_valid  input  1  a line is presented on line_data/line_offset.
REQ-007 line_ready  output  1  block accepts a line this cycle.
REQ-008 line_data  input  WORD_WIDTH*LINE_WORDS  line contents; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-009 line_offset  input  log2(LINE_WORDS)  requested (critical) word offset.
REQ-010 word_valid  output  1  word_data/word_index/word_last are valid.
REQ-011 word_ready  input  1  consumer accepts the current word.
REQ-012 word_data  output  WORD_WIDTH  extracted word.
REQ-013 word_index  output  log2(LINE_WORDS)  offset of word_data within the line.
REQ-014 word_last  output  1  current word is the final word of the line.
REQ-015 busy  output  1  a line is held and being streamed.

Function
REQ-016 The state machine SHALL have two states: IDLE and STREAM.
REQ-017 In IDLE, line_ready SHALL be 1, and word_valid, word_last and busy SHALL be 0.
REQ-018 In STREAM, line_ready SHALL be 0 and busy SHALL be 1; line_valid and line_data are ignored.
REQ-019 A line handshake is line_valid and line_ready both 1 at a rising edge; on it the block SHALL register line_data, load the start index, clear the word count and enter STREAM.
REQ-020 In STREAM, word_valid SHALL be 1 and word_data SHALL equal word[idx] of the registered line, with word_index equal to idx.
REQ-021 Every output SHALL be driven from registers or the registered line; there SHALL be no combinational path from any input to any output.
REQ-022 A word handshake is word_valid and word_ready both 1 at a rising edge; on it idx SHALL advance by 1 modulo LINE_WORDS (wrapping from LINE_WORDS-1 to 0) and the count SHALL increment.
REQ-023 word_last SHALL be 1 exactly when count equals LINE_WORDS-1.
REQ-024 A word handshake with word_last=1 SHALL return the block to IDLE.
REQ-025 While word_valid=1 and word_ready=0, word_data, word_index and word_last SHALL hold stable.
REQ-026 The first word_valid SHALL appear in the cycle after the line handshake, giving a latency of 1.
REQ-027 With word_ready held at 1, a line SHALL occupy exactly LINE_WORDS+1 cycles, and line_ready SHALL reassert in the cycle after the last word handshake.
REQ-028 Exactly LINE_WORDS word handshakes SHALL occur per line, and each index SHALL be emitted exactly once.
REQ-029 The registered line SHALL remain unchanged during STREAM, even if line_data changes.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with word_valid, word_last and busy at 0, and word_data and word_index at 0.
REQ-031 While rst_n=0, line_ready SHALL be 0; line_ready SHALL rise in the first clock cycle after rst_n deasserts.
REQ-032 A reset asserted during STREAM SHALL immediately abandon the line; no further words of that line SHALL be emitted after reset releases.

Configuration
REQ-033 With macro CRITICAL_WORD_FIRST_EN defined, the start index SHALL be line_offset, so streaming begins at the requested word and wraps around.
REQ-034 Without CRITICAL_WORD_FIRST_EN, the start index SHALL be 0, line_offset SHALL be ignored, and word_index SHALL run from 0 to LINE_WORDS-1.

Verification
REQ-035 The bench SHALL cover this case (macro off): a line whose word k = 0xA000_0000+k, word_ready held at 1 -> words 0xA0000000..0xA000000F at indices 0..15, word_last only on index 15, and line_ready high again 17 cycles after acceptance.
REQ-036 The bench SHALL cover this case (macro on): the same line with line_offset=13 -> indices 13,14,15,0,...,12, word_last on index 12, and word_data always equal to 0xA000_0000+index.
REQ-037 The bench SHALL cover this case: word_ready toggled 1,0,0,1 -> outputs hold during stall cycles, and no word is duplicated or skipped.
REQ-038 The bench SHALL cover this case: line_valid held at 1 with changing line_data during STREAM -> no second acceptance and the emitted words are unchanged.
REQ-039 The bench SHALL cover this case: rst_n pulsed low after the 5th word -> all outputs go to 0 asynchronously, line_ready=1 one cycle after release, and a new line streams from its correct start index.
REQ-040 The bench SHALL cover this case: back-to-back lines with line_valid held at 1 -> the second line is accepted in the cycle after the first line's word_last handshake.

Source files
------------

// File: rtl/line_serializer.sv
// Cache-line serializer: accepts a whole line, then streams it out one word per handshake.
// Optional CRITICAL_WORD_FIRST_EN starts streaming at line_offset and wraps; otherwise starts at word 0.
//
// state  | meaning
// IDLE   | no line held; line_ready high (except the first cycle after reset)
// STREAM | line registered; emitting word[idx] until the last word handshakes
module line_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 16,
    localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           line_valid,
    output logic                           line_ready,
    input  logic [WORD_WIDTH*LINE_WORDS-1:0] line_data,
    input  logic [IW-1:0]                  line_offset,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic [WORD_WIDTH-1:0]          word_data,
    output logic [IW-1:0]                  word_index,
    output logic                           word_last,
    output logic                           busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_POS = IW'(LINE_WORDS - 1);

    state_t                          state_q, state_d;
    logic [WORD_WIDTH*LINE_WORDS-1:0] line_q, line_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [IW-1:0]                   cnt_q, cnt_d;
    logic                            ready_q, ready_d;
    logic [IW-1:0]                   start_idx;
    logic                            streaming;
    logic                            last_word;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_idx = line_offset;
`else
    logic unused_offset;
    assign unused_offset = ^line_offset;
    assign start_idx     = '0;
`endif

    assign streaming = (state_q == STREAM);
    assign last_word = streaming && (cnt_q == LAST_POS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (line_valid && ready_q) begin
                    line_d  = line_data;
                    idx_d   = start_idx;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (word_ready) begin
                    idx_d = (idx_q == LAST_POS) ? '0 : idx_q + IW'(1);
                    cnt_d = cnt_q + IW'(1);
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // line_ready is registered so no input can reach it combinationally
        ready_d = (state_d == IDLE);
    end

    assign line_ready = ready_q;
    assign busy       = streaming;
    assign word_valid = streaming;
    assign word_last  = last_word;
    assign word_index = streaming ? idx_q : '0;
    assign word_data  = streaming ? line_q[idx_q*WORD_WIDTH +: WORD_WIDTH] : '0;

endmodule

// File: tb/tb_line_serializer.sv
// Self-checking bench for line_serializer; expected words come from a wrap-around index model.
// Build with +define+CRITICAL_WORD_FIRST_EN to exercise critical-word-first ordering.
`timescale 1ns/1ps
module tb_line_serializer;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             line_valid = 1'b0;
    logic             line_ready;
    logic [W*N-1:0]   line_data = '0;
    logic [IW-1:0]    line_offset = '0;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic [W-1:0]     word_data;
    logic [IW-1:0]    word_index;
    logic             word_last;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    line_serializer #(.WORD_WIDTH(W), .LINE_WORDS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .line_data   (line_data),
        .line_offset (line_offset),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_index  (word_index),
        .word_last   (word_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int start_of(input logic [IW-1:0] off);
`ifdef CRITICAL_WORD_FIRST_EN
        return int'(off);
`else
        return 0;
`endif
    endfunction

    function automatic logic [W*N-1:0] rand_line();
        logic [W*N-1:0] l;
        for (int k = 0; k < N; k++) l[k*W +: W] = $urandom;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high, 1: repeating 1,0,0,1, 2: random
    task automatic run_line(input logic [W*N-1:0] line, input logic [IW-1:0] off,
                            input int mode, input bit hold_valid, input int stop_after);
        int n;
        int guard;
        int exp_idx;
        bit rdy;
        check("ready_before_accept", line_ready, 1);
        line_valid  = 1'b1;
        line_data   = line;
        line_offset = off;
        tick();
        line_valid = hold_valid;
        check("busy_after_accept", {busy, line_ready}, 2'b10);
        n = 0;
        guard = 0;
        while (n < stop_after && guard < 200) begin
            exp_idx = (start_of(off) + n) % N;
            if (hold_valid) line_data = rand_line();
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 4 == 0) || (guard % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            word_ready = rdy;
            check("word_valid", word_valid, 1);
            check("line_ready_in_stream", line_ready, 0);
            check("word_index", word_index, exp_idx);
            check("word_data", word_data, line[exp_idx*W +: W]);
            check("word_last", word_last, (n == N-1));
            tick();
            guard++;
            if (rdy) n++;
        end
        word_ready = 1'b0;
        if (n < stop_after) check("stream_timeout", n, stop_after);
        if (stop_after == N) begin
            check("line_ready_after_last", line_ready, 1);
            check("idle_outputs", {word_valid, word_last, busy}, 3'b000);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W*N-1:0] seq_line;
        for (int k = 0; k < N; k++) seq_line[k*W +: W] = 32'hA000_0000 + k;

        #3;
        check("reset_ctrl", {line_ready, word_valid, word_last, busy}, 4'b0000);
        check("reset_data", {word_data, word_index}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("ready_low_before_edge", line_ready, 0);
        tick();
        check("ready_after_release", line_ready, 1);

        // incrementing line, offset 13, ready held high
        run_line(seq_line, 4'd13, 0, 1'b0, N);
        tick();

        // stall pattern 1,0,0,1
        run_line(rand_line(), 4'($urandom_range(0, N-1)), 1, 1'b0, N);

        // line_valid held with changing data during the stream, then back-to-back
        run_line(rand_line(), 4'($urandom_range(0, N-1)), 2, 1'b1, N);
        run_line(rand_line(), 4'($urandom_range(0, N-1)), 0, 1'b1, N);
        run_line(rand_line(), 4'($urandom_range(0, N-1)), 2, 1'b1, N);
        line_valid = 1'b0;
        tick();

        // reset mid-line after the 5th word
        run_line(rand_line(), 4'($urandom_range(0, N-1)), 0, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {line_ready, word_valid, word_last, busy}, 4'b0000);
        check("midreset_data", {word_data, word_index}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("midreset_ready_low", line_ready, 0);
        tick();
        check("midreset_ready_high", {line_ready, word_valid}, 2'b10);
        run_line(rand_line(), 4'($urandom_range(0, N-1)), 0, 1'b0, N);

        for (int i = 0; i < 4; i++) begin
            run_line(rand_line(), 4'($urandom_range(0, N-1)), 2, 1'($urandom_range(0, 1)), N);
            line_valid = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
